// File: rtl/mips_pkg.sv
// mips_pkg: shared constants and instruction classification for the MIPS
// pipeline control blocks.
//   - opcode / funct constants
//   - Tuse / Tnew constants (TUSE_NONE = 7 means the operand is never read)
//   - register-zero constant
//   - decode_class(): maps a 32-bit instruction to its hazard class
// Macro HAZARD_MD_EN: when undefined, mult/div, mfhi/mflo and mthi/mtlo
// classify as nop.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0c;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_LB    = 6'h20;
    localparam logic [5:0] OP_LH    = 6'h21;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SB    = 6'h28;
    localparam logic [5:0] OP_SH    = 6'h29;
    localparam logic [5:0] OP_SW    = 6'h2b;

    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MTHI  = 6'h11;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MTLO  = 6'h13;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIV   = 6'h1a;
    localparam logic [5:0] FN_DIVU  = 6'h1b;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_SLT   = 6'h2a;
    localparam logic [5:0] FN_SLTU  = 6'h2b;

    localparam int TUSE_0    = 0;
    localparam int TUSE_1    = 1;
    localparam int TUSE_2    = 2;
    localparam int TUSE_NONE = 7;
    localparam int TNEW_0    = 0;
    localparam int TNEW_1    = 1;
    localparam int TNEW_2    = 2;

    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam logic [4:0] REG_RA   = 5'd31;

    typedef enum logic [3:0] {
        CLS_NOP, CLS_CAL_R, CLS_CAL_I, CLS_LUI, CLS_BRANCH, CLS_LOAD,
        CLS_STORE, CLS_JAL, CLS_JR, CLS_MD, CLS_MF, CLS_MT
    } instr_class_e;

    // R-type encodings with a non-zero shamt field are not valid forms of
    // any tracked instruction, so they fall through to nop.
    function automatic instr_class_e decode_class(input logic [31:0] instr);
        instr_class_e cls;
        cls = CLS_NOP;
        case (instr[31:26])
            OP_RTYPE: begin
                if (instr[10:6] == 5'd0) begin
                    case (instr[5:0])
                        FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT, FN_SLTU: cls = CLS_CAL_R;
                        FN_JR:                                          cls = CLS_JR;
`ifdef HAZARD_MD_EN
                        FN_MULT, FN_MULTU, FN_DIV, FN_DIVU:             cls = CLS_MD;
                        FN_MFHI, FN_MFLO:                               cls = CLS_MF;
                        FN_MTHI, FN_MTLO:                               cls = CLS_MT;
`endif
                        default:                                        cls = CLS_NOP;
                    endcase
                end
            end
            OP_ORI, OP_ADDI, OP_ANDI: cls = CLS_CAL_I;
            OP_LUI:                   cls = CLS_LUI;
            OP_BEQ, OP_BNE:           cls = CLS_BRANCH;
            OP_LW, OP_LH, OP_LB:      cls = CLS_LOAD;
            OP_SW, OP_SH, OP_SB:      cls = CLS_STORE;
            OP_JAL:                   cls = CLS_JAL;
            default:                  cls = CLS_NOP;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/md_busy_counter.sv
// md_busy_counter: occupancy timer for the multi-cycle mult/div unit.
//   clk, reset : clock, async active-high reset
//   start      : md instruction issues this cycle
//   is_div     : issuing instruction is div/divu (else mult/multu)
//   busy       : unit occupied (counter non-zero)
// Down-counter: loads the op latency on start, otherwise counts to zero.
module md_busy_counter #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic is_div,
    output logic busy
);

    localparam int CNT_W = $clog2(DIV_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (start) begin
            cnt_q <= is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    assign busy = (cnt_q != '0);

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: Tuse/Tnew stall controller for the five-stage MIPS pipeline.
//   clk, reset          : clock, async active-high reset
//   Instr_D             : instruction in the D-stage register
//   stall               : D instruction must wait
//   IFU_en / D_REG_en   : ~stall
//   E_REG_clr           : stall (injects a bubble into E)
//   Tnew_D, A3_D        : decoded Tnew / destination of Instr_D
//   A3_pipe, Tnew_pipe  : tracked producers, entry k = stage E+k
//   md_busy             : mult/div unit occupied
// Macro HAZARD_MD_EN: enables md/mf/mt decode and the mult/div busy counter;
// when undefined md_busy is tied low.
module hazard_ctrl
    import mips_pkg::*;
#(
    parameter int STAGES      = 2,
    parameter int TW          = 3,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [31:0]            Instr_D,
    output logic                   stall,
    output logic                   IFU_en,
    output logic                   D_REG_en,
    output logic                   E_REG_clr,
    output logic [TW-1:0]          Tnew_D,
    output logic [4:0]             A3_D,
    output logic [5*STAGES-1:0]    A3_pipe,
    output logic [TW*STAGES-1:0]   Tnew_pipe,
    output logic                   md_busy
);

    instr_class_e cls;
    logic [4:0]    rs;
    logic [4:0]    rt;
    logic [4:0]    rd;
    logic [TW-1:0] tuse_rs;
    logic [TW-1:0] tuse_rt;
    logic          hazard;
    logic          md_stall;

    logic [4:0]    a3_q   [STAGES];
    logic [TW-1:0] tnew_q [STAGES];

    assign cls = decode_class(Instr_D);
    assign rs  = Instr_D[25:21];
    assign rt  = Instr_D[20:16];
    assign rd  = Instr_D[15:11];

    always_comb begin
        Tnew_D  = TW'(TNEW_0);
        A3_D    = REG_ZERO;
        tuse_rs = TW'(TUSE_NONE);
        tuse_rt = TW'(TUSE_NONE);
        case (cls)
            CLS_CAL_R:  begin Tnew_D = TW'(TNEW_1); A3_D = rd;     tuse_rs = TW'(TUSE_1); tuse_rt = TW'(TUSE_1); end
            CLS_CAL_I:  begin Tnew_D = TW'(TNEW_1); A3_D = rt;     tuse_rs = TW'(TUSE_1); end
            CLS_LUI:    begin Tnew_D = TW'(TNEW_0); A3_D = rt;     end
            CLS_BRANCH: begin tuse_rs = TW'(TUSE_0); tuse_rt = TW'(TUSE_0); end
            CLS_LOAD:   begin Tnew_D = TW'(TNEW_2); A3_D = rt;     tuse_rs = TW'(TUSE_1); end
            CLS_STORE:  begin tuse_rs = TW'(TUSE_1); tuse_rt = TW'(TUSE_2); end
            CLS_JAL:    begin Tnew_D = TW'(TNEW_0); A3_D = REG_RA; end
            CLS_JR:     begin tuse_rs = TW'(TUSE_0); end
            CLS_MD:     begin tuse_rs = TW'(TUSE_1); tuse_rt = TW'(TUSE_1); end
            CLS_MF:     begin Tnew_D = TW'(TNEW_1); A3_D = rd;     end
            CLS_MT:     begin tuse_rs = TW'(TUSE_1); end
            default:    begin end
        endcase
    end

    // A source is outstanding when a tracked producer writes it and will not
    // have its result ready by the time this instruction needs it.
    always_comb begin
        hazard = 1'b0;
        for (int k = 0; k < STAGES; k++) begin
            if ((tuse_rs < tnew_q[k]) && (rs == a3_q[k]) && (rs != REG_ZERO))
                hazard = 1'b1;
            if ((tuse_rt < tnew_q[k]) && (rt == a3_q[k]) && (rt != REG_ZERO))
                hazard = 1'b1;
        end
    end

    assign md_stall  = md_busy && (cls inside {CLS_MD, CLS_MF, CLS_MT});
    assign stall     = hazard | md_stall;
    assign IFU_en    = ~stall;
    assign D_REG_en  = ~stall;
    assign E_REG_clr = stall;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < STAGES; k++) begin
                a3_q[k]   <= REG_ZERO;
                tnew_q[k] <= '0;
            end
        end else begin
            a3_q[0]   <= stall ? REG_ZERO : A3_D;
            tnew_q[0] <= stall ? '0 : Tnew_D;
            for (int k = 1; k < STAGES; k++) begin
                a3_q[k]   <= a3_q[k-1];
                tnew_q[k] <= (tnew_q[k-1] == '0) ? '0 : tnew_q[k-1] - TW'(1);
            end
        end
    end

    for (genvar g = 0; g < STAGES; g++) begin : g_pipe_out
        assign A3_pipe[5*g +: 5]     = a3_q[g];
        assign Tnew_pipe[TW*g +: TW] = tnew_q[g];
    end

`ifdef HAZARD_MD_EN
    md_busy_counter #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES)
    ) u_md_busy_counter (
        .clk    (clk),
        .reset  (reset),
        .start  ((cls == CLS_MD) && !stall),
        .is_div (Instr_D[1]),
        .busy   (md_busy)
    );
`else
    assign md_busy = 1'b0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;
    localparam int STAGES = 2;
    localparam int TW     = 3;
`ifdef HAZARD_MD_EN
    localparam logic MD_EN = 1'b1;
`else
    localparam logic MD_EN = 1'b0;
`endif

    logic                 clk;
    logic                 reset;
    logic [31:0]          Instr_D;
    logic                 stall, IFU_en, D_REG_en, E_REG_clr, md_busy;
    logic [TW-1:0]        Tnew_D;
    logic [4:0]           A3_D;
    logic [5*STAGES-1:0]  A3_pipe;
    logic [TW*STAGES-1:0] Tnew_pipe;

    int checks = 0;
    int errors = 0;

    hazard_ctrl #(.STAGES(STAGES), .TW(TW), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .Instr_D(Instr_D), .stall(stall), .IFU_en(IFU_en),
        .D_REG_en(D_REG_en), .E_REG_clr(E_REG_clr), .Tnew_D(Tnew_D), .A3_D(A3_D),
        .A3_pipe(A3_pipe), .Tnew_pipe(Tnew_pipe), .md_busy(md_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] r_ins(input logic [5:0] fn, input logic [4:0] s, input logic [4:0] t, input logic [4:0] d);
        return {6'h00, s, t, d, 5'd0, fn};
    endfunction

    function automatic logic [31:0] i_ins(input logic [5:0] op, input logic [4:0] s, input logic [4:0] t, input logic [15:0] imm);
        return {op, s, t, imm};
    endfunction

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one edge (committing the previous D instruction), present a new
    // instruction, and settle at the falling edge for checking.
    task automatic drive(input logic [31:0] ins);
        @(posedge clk);
        #1;
        Instr_D = ins;
        #4;
    endtask

    task automatic flush;
        repeat (STAGES + 1) drive(32'd0);
    endtask

    logic [31:0] LW1, ADD213, ADD456, BEQ40, ORI00, BEQ00, JAL, LUI7;
    logic [31:0] LW9, SW9_DATA, SW9_BASE, LW10, BEQ10, MULT12, MFLO3, DIV12, ORI8;

    initial begin
        LW1      = i_ins(6'h23, 5'd0, 5'd1, 16'd0);
        ADD213   = r_ins(6'h20, 5'd1, 5'd3, 5'd2);
        ADD456   = r_ins(6'h20, 5'd5, 5'd6, 5'd4);
        BEQ40    = i_ins(6'h04, 5'd4, 5'd0, 16'd4);
        ORI00    = i_ins(6'h0d, 5'd0, 5'd0, 16'd1);
        BEQ00    = i_ins(6'h04, 5'd0, 5'd0, 16'd4);
        JAL      = {6'h03, 26'h10};
        LUI7     = i_ins(6'h0f, 5'd0, 5'd7, 16'h1234);
        LW9      = i_ins(6'h23, 5'd0, 5'd9, 16'd0);
        SW9_DATA = i_ins(6'h2b, 5'd0, 5'd9, 16'd4);
        SW9_BASE = i_ins(6'h2b, 5'd9, 5'd0, 16'd4);
        LW10     = i_ins(6'h21, 5'd0, 5'd10, 16'd0);
        BEQ10    = i_ins(6'h05, 5'd10, 5'd0, 16'd4);
        MULT12   = r_ins(6'h18, 5'd1, 5'd2, 5'd0);
        MFLO3    = r_ins(6'h12, 5'd0, 5'd0, 5'd3);
        DIV12    = r_ins(6'h1a, 5'd1, 5'd2, 5'd0);
        ORI8     = i_ins(6'h0d, 5'd0, 5'd8, 16'd1);

        reset   = 1'b1;
        Instr_D = LW1;
        #2;
        check_val("rst_md_busy", md_busy, 0);
        check_val("rst_a3_pipe", A3_pipe, 0);
        check_val("rst_tnew_pipe", Tnew_pipe, 0);
        check_val("rst_stall", stall, 0);
        #6 reset = 1'b0;

        // load-use
        drive(LW1);
        check_val("lw_tnew_d", Tnew_D, 2);
        check_val("lw_a3_d", A3_D, 1);
        check_val("lw_stall", stall, 0);
        drive(ADD213);
        check_val("lu_stall", stall, 1);
        check_val("lu_ifu_en", IFU_en, 0);
        check_val("lu_dreg_en", D_REG_en, 0);
        check_val("lu_eclr", E_REG_clr, 1);
        drive(ADD213);
        check_val("lu_stall2", stall, 0);
        check_val("lu_bubble_a3", A3_pipe, 32'd1 << 5);
        check_val("lu_bubble_tnew", Tnew_pipe, 32'd1 << TW);
        flush();

        // branch after ALU
        drive(ADD456);
        check_val("add_tnew_d", Tnew_D, 1);
        check_val("add_a3_d", A3_D, 4);
        drive(BEQ40);
        check_val("br_stall", stall, 1);
        drive(BEQ40);
        check_val("br_stall2", stall, 0);
        check_val("br_a3_m", A3_pipe, 32'd4 << 5);
        check_val("br_tnew_m", Tnew_pipe, 0);
        flush();

        // register zero
        drive(ORI00);
        check_val("ori0_a3_d", A3_D, 0);
        check_val("ori0_tnew_d", Tnew_D, 1);
        drive(BEQ00);
        check_val("r0_stall", stall, 0);
        flush();

        // decode spot checks
        drive(JAL);
        check_val("jal_a3", A3_D, 31);
        check_val("jal_tnew", Tnew_D, 0);
        drive(LUI7);
        check_val("lui_a3", A3_D, 7);
        check_val("lui_tnew", Tnew_D, 0);
        flush();

        // store data (Tuse 2) vs store base (Tuse 1) after load
        drive(LW9);
        drive(SW9_DATA);
        check_val("sw_data_stall", stall, 0);
        flush();
        drive(LW9);
        drive(SW9_BASE);
        check_val("sw_base_stall", stall, 1);
        flush();

        // producer in M stage against branch
        drive(LW10);
        drive(32'd0);
        drive(BEQ10);
        check_val("m_stage_stall", stall, 1);
        drive(BEQ10);
        check_val("m_stage_clear", stall, 0);
        flush();

        // mult then mflo
        drive(MULT12);
        check_val("mult_issue_stall", stall, 0);
        check_val("mult_issue_busy", md_busy, 0);
        for (int i = 0; i < 5; i++) begin
            drive(MFLO3);
            check_val("mult_busy", md_busy, 32'(MD_EN));
            check_val("mflo_stall", stall, 32'(MD_EN));
        end
        drive(MFLO3);
        check_val("mflo_issue_busy", md_busy, 0);
        check_val("mflo_issue_stall", stall, 0);
        check_val("mflo_a3", A3_D, MD_EN ? 32'd3 : 32'd0);
        check_val("mflo_tnew", Tnew_D, MD_EN ? 32'd1 : 32'd0);
        flush();

        // div then mult
        drive(DIV12);
        check_val("div_issue_stall", stall, 0);
        for (int i = 0; i < 10; i++) begin
            drive(MULT12);
            check_val("div_busy", md_busy, 32'(MD_EN));
            check_val("div_mult_stall", stall, 32'(MD_EN));
        end
        drive(MULT12);
        check_val("mult2_issue_stall", stall, 0);
        check_val("mult2_issue_busy", md_busy, 0);
        for (int i = 0; i < 5; i++) begin
            drive(32'd0);
            check_val("mult2_busy", md_busy, 32'(MD_EN));
        end
        drive(32'd0);
        check_val("mult2_done", md_busy, 0);
        flush();

        // reset during 4th busy cycle of a div
        drive(DIV12);
        drive(ORI8);
        drive(ORI8);
        drive(ORI8);
        drive(MFLO3);
        check_val("pre_rst_busy", md_busy, 32'(MD_EN));
        check_val("pre_rst_stall", stall, 32'(MD_EN));
        check_val("pre_rst_a3", A3_pipe, (32'd8 << 5) | 32'd8);
        check_val("pre_rst_tnew", Tnew_pipe, 1);
        #1 reset = 1'b1;
        #1;
        check_val("mid_rst_busy", md_busy, 0);
        check_val("mid_rst_a3", A3_pipe, 0);
        check_val("mid_rst_tnew", Tnew_pipe, 0);
        check_val("mid_rst_stall", stall, 0);
        #1 reset = 1'b0;
        drive(MFLO3);
        check_val("post_rst_stall", stall, 0);
        drive(32'd0);
        check_val("post_rst_issue_a3", A3_pipe[4:0], MD_EN ? 32'd3 : 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
